// File: rtl/pc_pkg.sv
// Shared encodings for the fetch PC sequencer: FSM states, redirect-select codes, default reset vector.
package pc_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      SEL_SEQ = 2'd0,
      SEL_BR  = 2'd1,
      SEL_J   = 2'd2,
      SEL_JR  = 2'd3
   } sel_e;

   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/stall bundle into the PC sequencer and the fetch-address outputs back out.
// misalign_err only exists when PC_ALIGN_CHECK_EN is defined.
interface pc_sequencer_if #(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 26,
   parameter int IMM_W   = 16
);
   logic               stall;
   logic               branch_taken;
   logic [IMM_W-1:0]   branch_imm;
   logic               jump;
   logic [INDEX_W-1:0] jump_index;
   logic               jump_reg;
   logic [ADDR_W-1:0]  jr_target;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  pc_plus4;
   logic               redirect_pending;
`ifdef PC_ALIGN_CHECK_EN
   logic               misalign_err;

   modport master (
      output stall, branch_taken, branch_imm, jump, jump_index, jump_reg, jr_target,
      input  pc, pc_plus4, redirect_pending, misalign_err
   );
   modport slave (
      input  stall, branch_taken, branch_imm, jump, jump_index, jump_reg, jr_target,
      output pc, pc_plus4, redirect_pending, misalign_err
   );
`else
   modport master (
      output stall, branch_taken, branch_imm, jump, jump_index, jump_reg, jr_target,
      input  pc, pc_plus4, redirect_pending
   );
   modport slave (
      input  stall, branch_taken, branch_imm, jump, jump_index, jump_reg, jr_target,
      output pc, pc_plus4, redirect_pending
   );
`endif
endinterface

// File: rtl/pc_target_calc.sv
// Combinational redirect target formation and priority select (jump_reg > jump > branch).
// PC_ALIGN_CHECK_EN: flags misaligned jump_reg targets and forces their low two bits to zero.
module pc_target_calc
   import pc_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 26,
   parameter int IMM_W   = 16
) (
   input  logic [ADDR_W-1:0]  i_pc_plus4,
   input  logic               i_branch_taken,
   input  logic [IMM_W-1:0]   i_branch_imm,
   input  logic               i_jump,
   input  logic [INDEX_W-1:0] i_jump_index,
   input  logic               i_jump_reg,
   input  logic [ADDR_W-1:0]  i_jr_target,
   output logic [ADDR_W-1:0]  o_sel_tgt,
`ifdef PC_ALIGN_CHECK_EN
   output logic               o_jr_misalign,
`endif
   output logic               o_redirect
);

   logic [ADDR_W-1:0] w_imm_sext;
   logic [ADDR_W-1:0] w_br_tgt;
   logic [ADDR_W-1:0] w_j_tgt;
   logic [ADDR_W-1:0] w_jr_tgt;
   sel_e              w_sel;

   assign w_imm_sext = ADDR_W'($signed(i_branch_imm));
   assign w_br_tgt   = i_pc_plus4 + (w_imm_sext << 2);

   // The upper region bits come from pc+4; when the index fills the word there are none.
   generate
      if (ADDR_W == INDEX_W + 2) begin : g_j_no_upper
         assign w_j_tgt = {i_jump_index, 2'b00};
      end else begin : g_j_upper
         assign w_j_tgt = {i_pc_plus4[ADDR_W-1:INDEX_W+2], i_jump_index, 2'b00};
      end
   endgenerate

`ifdef PC_ALIGN_CHECK_EN
   assign w_jr_tgt      = {i_jr_target[ADDR_W-1:2], 2'b00};
   assign o_jr_misalign = i_jump_reg && (i_jr_target[1:0] != 2'b00);
`else
   assign w_jr_tgt      = i_jr_target;
`endif

   always_comb begin
      w_sel = SEL_SEQ;
      if (i_jump_reg) begin
         w_sel = SEL_JR;
      end else if (i_jump) begin
         w_sel = SEL_J;
      end else if (i_branch_taken) begin
         w_sel = SEL_BR;
      end
   end

   always_comb begin
      o_sel_tgt = i_pc_plus4;
      case (w_sel)
         SEL_JR:  o_sel_tgt = w_jr_tgt;
         SEL_J:   o_sel_tgt = w_j_tgt;
         SEL_BR:  o_sel_tgt = w_br_tgt;
         default: o_sel_tgt = i_pc_plus4;
      endcase
   end

   assign o_redirect = i_jump_reg | i_jump | i_branch_taken;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with a one-entry pending-redirect buffer so redirects survive a stall.
// PC_ALIGN_CHECK_EN adds a sticky misalign_err for misaligned jump_reg targets.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int               ADDR_W    = 32,
   parameter int               INDEX_W   = 26,
   parameter int               IMM_W     = 16,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC)
) (
   input  logic          clk,
   input  logic          rst_n,
   pc_sequencer_if.slave bus
);

   state_e            r_state;
   state_e            w_state_next;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic [ADDR_W-1:0] r_pend_tgt;
   logic [ADDR_W-1:0] w_pend_next;
   logic [ADDR_W-1:0] w_pc_plus4;
   logic [ADDR_W-1:0] w_sel_tgt;
   logic              w_redirect;

   assign w_pc_plus4 = r_pc + ADDR_W'(4);

`ifdef PC_ALIGN_CHECK_EN
   logic w_jr_misalign;
   logic r_misalign_err;
`endif

   pc_target_calc #(
      .ADDR_W  (ADDR_W),
      .INDEX_W (INDEX_W),
      .IMM_W   (IMM_W)
   ) u_target_calc (
      .i_pc_plus4     (w_pc_plus4),
      .i_branch_taken (bus.branch_taken),
      .i_branch_imm   (bus.branch_imm),
      .i_jump         (bus.jump),
      .i_jump_index   (bus.jump_index),
      .i_jump_reg     (bus.jump_reg),
      .i_jr_target    (bus.jr_target),
      .o_sel_tgt      (w_sel_tgt),
`ifdef PC_ALIGN_CHECK_EN
      .o_jr_misalign  (w_jr_misalign),
`endif
      .o_redirect     (w_redirect)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_VEC;
         r_pend_tgt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_pend_tgt <= w_pend_next;
      end
   end

   // In PEND the buffered target belongs to the older instruction, so new redirects are dropped.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_pend_next  = r_pend_tgt;
      case (r_state)
         ST_RUN: begin
            if (!bus.stall) begin
               w_pc_next = w_redirect ? w_sel_tgt : w_pc_plus4;
            end else if (w_redirect) begin
               w_pend_next  = w_sel_tgt;
               w_state_next = ST_PEND;
            end
         end
         ST_PEND: begin
            if (!bus.stall) begin
               w_pc_next    = r_pend_tgt;
               w_state_next = ST_RUN;
            end
         end
         default: w_state_next = ST_RUN;
      endcase
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign_err <= 1'b0;
      end else if ((r_state == ST_RUN) && w_jr_misalign) begin
         r_misalign_err <= 1'b1;
      end
   end

   assign bus.misalign_err = r_misalign_err;
`endif

   assign bus.pc               = r_pc;
   assign bus.pc_plus4         = w_pc_plus4;
   assign bus.redirect_pending = (r_state == ST_PEND);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected pc/state, a monitor pops and compares.
module tb_pc_sequencer;

   localparam int ADDR_W  = 32;
   localparam int INDEX_W = 26;
   localparam int IMM_W   = 16;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        pend;
      logic        err;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   logic exp_err = 1'b0;
   event sample_ev;

   always #5 clk = ~clk;

   pc_sequencer_if #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .IMM_W(IMM_W)) bus ();

   pc_sequencer #(
      .ADDR_W    (ADDR_W),
      .INDEX_W   (INDEX_W),
      .IMM_W     (IMM_W),
      .RESET_VEC (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic push(input string name, input logic [31:0] pc, input logic pend);
      exp_t e;
      e.name = name;
      e.pc   = pc;
      e.pend = pend;
      e.err  = exp_err;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic st, input logic br, input logic [15:0] imm,
                        input logic j, input logic [25:0] idx,
                        input logic jr, input logic [31:0] jrt);
      bus.stall        = st;
      bus.branch_taken = br;
      bus.branch_imm   = imm;
      bus.jump         = j;
      bus.jump_index   = idx;
      bus.jump_reg     = jr;
      bus.jr_target    = jrt;
   endtask

   // Drive inputs, take one clock edge, then queue the state expected after that edge.
   task automatic apply(input string name, input logic st, input logic br, input logic [15:0] imm,
                        input logic j, input logic [25:0] idx,
                        input logic jr, input logic [31:0] jrt,
                        input logic [31:0] epc, input logic epend);
      drive(st, br, imm, j, idx, jr, jrt);
      @(posedge clk);
      #1;
      push(name, epc, epend);
   endtask

   task automatic seq(input string name, input logic [31:0] epc);
      apply(name, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, epc, 1'b0);
   endtask

   always begin : monitor
      exp_t        e;
      logic [31:0] p4;
      @(negedge clk or sample_ev);
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         p4 = e.pc + 32'd4;
         $display("vec %s: pc=%h pc_plus4=%h pend=%b", e.name, bus.pc, bus.pc_plus4, bus.redirect_pending);
         n_vec++;
         if (bus.pc !== e.pc) begin
            n_miss++;
            $display("FAIL %s pc: got %h want %h", e.name, bus.pc, e.pc);
         end
         n_vec++;
         if (bus.pc_plus4 !== p4) begin
            n_miss++;
            $display("FAIL %s pc_plus4: got %h want %h", e.name, bus.pc_plus4, p4);
         end
         n_vec++;
         if (bus.redirect_pending !== e.pend) begin
            n_miss++;
            $display("FAIL %s redirect_pending: got %b want %b", e.name, bus.redirect_pending, e.pend);
         end
`ifdef PC_ALIGN_CHECK_EN
         n_vec++;
         if (bus.misalign_err !== e.err) begin
            n_miss++;
            $display("FAIL %s misalign_err: got %b want %b", e.name, bus.misalign_err, e.err);
         end
`endif
      end
   end

   initial begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);

      // Reset is seen before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      push("reset", 32'h0, 1'b0);
      ->sample_ev;
      @(negedge clk);
      rst_n = 1'b1;

      seq("seq_4", 32'h4);
      seq("seq_8", 32'h8);
      seq("seq_c", 32'hC);

      apply("jr_load", 0, 0, 16'h0, 0, 26'h0, 1, 32'h4000_0010, 32'h4000_0010, 0);
      apply("jump",    0, 0, 16'h0, 1, 26'h0000100, 0, 32'h0, 32'h4000_0400, 0);
      apply("jr_100",  0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_0100, 32'h0000_0100, 0);
      apply("br_neg",  0, 1, 16'hFFFF, 0, 26'h0, 0, 32'h0, 32'h0000_0100, 0);
      apply("br_pos",  0, 1, 16'h0010, 0, 26'h0, 0, 32'h0, 32'h0000_0144, 0);

      apply("prio_all", 0, 1, 16'h0001, 1, 26'h5, 1, 32'h0000_2000, 32'h0000_2000, 0);
      apply("prio_j_br", 0, 1, 16'h0001, 1, 26'h40, 0, 32'h0, 32'h0000_0100, 0);

      // Stall with a branch to 0x200 buffered; a later jump must not replace it.
      apply("stall_br",   1, 1, 16'h003F, 0, 26'h0, 0, 32'h0, 32'h0000_0100, 1);
      apply("stall_hold", 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0000_0100, 1);
      apply("stall_jump", 1, 0, 16'h0, 1, 26'h999, 0, 32'h0, 32'h0000_0100, 1);
      apply("release",    0, 0, 16'h0, 1, 26'h777, 0, 32'h0, 32'h0000_0200, 0);
      seq("after_rel", 32'h0000_0204);
      apply("stall_norun", 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0000_0204, 0);

      apply("jr_top",  0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
      seq("wrap_seq", 32'h0);
      apply("wrap_br", 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 32'hFFFF_FFFC, 0);

      // Reset during PEND discards the buffered target without waiting for a clock.
      apply("pend_again", 1, 0, 16'h0, 1, 26'h3, 0, 32'h0, 32'hFFFF_FFFC, 1);
      @(negedge clk);
      #1;
      drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      push("async_rst", 32'h0, 1'b0);
      ->sample_ev;
      #1 rst_n = 1'b1;
      seq("post_rst", 32'h4);

`ifdef PC_ALIGN_CHECK_EN
      exp_err = 1'b1;
      apply("jr_misalign", 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_1002, 32'h0000_1000, 0);
      seq("err_sticky1", 32'h0000_1004);
      seq("err_sticky2", 32'h0000_1008);
`else
      apply("jr_unaligned", 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_1002, 32'h0000_1002, 0);
      seq("unaligned_seq", 32'h0000_1006);
`endif

      drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch program counter for the MIPS datapath.
- Each cycle, selects the next PC from sequential, branch, jump and jump-register sources.
- Generalises jump-target formation ({PC+4 upper bits, index, 00}) to parametrised widths.
- Adds stall handling with a pending-redirect buffer, so no redirect is lost while fetch is frozen.

Parameters:
- ADDR_W, 32: PC/address width; must be >= INDEX_W+2.
- INDEX_W, 26: jump instruction index field width.
- IMM_W, 16: branch immediate width, sign-extended.
- RESET_VEC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  freeze PC this cycle
- branch_taken  in  1  conditional branch resolved taken
- branch_imm  in  IMM_W  branch offset, in words
- jump  in  1  J/JAL redirect
- jump_index  in  INDEX_W  instr[INDEX_W-1:0]
- jump_reg  in  1  JR/JALR redirect
- jr_target  in  ADDR_W  register-sourced target
- pc  out  ADDR_W  current fetch address (registered)
- pc_plus4  out  ADDR_W  pc+4, combinational from pc
- redirect_pending  out  1  a redirect is buffered (state PEND)
- misalign_err  out  1  sticky; only exists with PC_ALIGN_CHECK_EN

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VEC, state=RUN, pending target cleared, redirect_pending=0, misalign_err=0.
- Arithmetic, all modulo 2^ADDR_W, wrap silent:
  - pc_plus4 = pc+4.
  - br_tgt = pc_plus4 + (sext(branch_imm)<<2).
  - j_tgt = {pc_plus4[ADDR_W-1:INDEX_W+2], jump_index, 2'b00}. If ADDR_W==INDEX_W+2, there are no upper bits.
- Redirect priority: jump_reg > jump > branch_taken. sel_tgt is the highest asserted. A redirect is requested when any of the three is asserted.
- State RUN:
  - stall=0, redirect: pc<=sel_tgt.
  - stall=0, no redirect: pc<=pc_plus4.
  - stall=1, redirect: pc held; pend_tgt<=sel_tgt; go to PEND.
  - stall=1, no redirect: pc held.
- State PEND:
  - stall=1: pc held. A new redirect is ignored; the oldest redirect wins.
  - stall=0: pc<=pend_tgt; go to RUN. Any redirect input in this cycle is ignored, because the buffered one belongs to the older instruction.
- redirect_pending=1 iff state==PEND (registered).
- Latency: redirect to pc update is one clock edge. pc_plus4 has zero latency from pc.
- Reset asserted mid-PEND: the pending target is discarded; pc=RESET_VEC.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- With the macro:
  - A jump_reg target with jr_target[1:0]!=0 sets misalign_err (sticky until reset).
  - The target is still used with the low 2 bits forced to 00.
- Without the macro:
  - The misalign_err port is absent.
  - jr_target is used unmodified.

Decomposition:
- Shared package pc_pkg holds:
  - state encoding (ST_RUN=1'b0, ST_PEND=1'b1)
  - redirect-select encoding (SEL_SEQ, SEL_BR, SEL_J, SEL_JR)
  - default RESET_VEC constant
- One natural sub-module: pc_target_calc. It is purely combinational and produces br_tgt, j_tgt, sel_tgt and the redirect-request flag. The FSM and registers stay in pc_sequencer.

Test Plan:
1. Reset sequence: rst_n=0 at any point, then 3 free-running cycles -> pc=0x0, then 0x4, 0x8, 0xC.
2. Jump: pc=0x4000_0010, jump=1, jump_index=0x0000100 -> next pc=0x4000_0400. Branch: pc=0x100, branch_imm=0xFFFF -> next pc=0x100.
3. Priority: jump_reg=1 (jr_target=0x2000), jump=1, branch_taken=1 all in one cycle -> pc=0x2000.
4. Stall buffering: stall=1 with branch_taken (target 0x200), held 3 cycles, then a jump during the stall -> pc constant, redirect_pending=1; on stall release pc=0x200, not the jump target.
5. Wrap and reset mid-PEND: pc=0xFFFF_FFFC sequential -> pc=0x0. Assert rst_n=0 while in PEND -> pc=RESET_VEC and redirect_pending=0 immediately, asynchronously.
6. With PC_ALIGN_CHECK_EN: jump_reg with jr_target=0x1002 -> pc=0x1000 and misalign_err=1, which stays 1 through subsequent cycles.
